cache_fill_fsm: RTL and testbench
=================================

Name: cache_fill_fsm

Overview:
- Miss handler between the CPU's I-/D-cache and the shared multi-cycle main memory. One instance per cache.
- On a miss it fetches the full 16-byte block (8 x 16-bit words) from a pipelined memory with fixed read latency.
- It drives per-word writes into the cache data array, then a single tag-array write.
- fsm_busy stalls the pipeline for the whole fill.

Parameters:
- WORDS_PER_BLOCK, 8, 16-bit words per cache block; power of two, >=2. Block bytes = 2*WORDS_PER_BLOCK.
- MEM_LATENCY, 4, cycles from a read request (mem_read_en high at edge) to its memory_data_valid; informative only, the FSM counts returned valids and does not time them.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- miss_detected  in  1  cache lookup missed this cycle.
- miss_address  in  16  byte address of the missing access.
- memory_data_valid  in  1  memory returns one requested word this cycle.
- fsm_busy  out  1  fill in progress.
- mem_read_en  out  1  read request to memory this cycle.
- memory_address  out  16  byte address of the current request.
- write_data_array  out  1  write the returned word into the data array.
- word_index  out  log2(WORDS_PER_BLOCK)  word slot for write_data_array.
- write_tag_array  out  1  one-cycle pulse: write tag and set valid for the filled block.

Behaviour:
- Reset (synchronous, any state): go to IDLE. Clear both counters and the latched base. All outputs = 0 (fsm_busy, mem_read_en, memory_address=16'h0000, write_data_array, word_index=0, write_tag_array).
- States: IDLE, FILL.
- IDLE, miss_detected=1 at edge:
  - latch base = miss_address with low log2(2*WORDS_PER_BLOCK) bits cleared (16'hFFF0 mask for default);
  - req_cnt=0, rcv_cnt=0; go to FILL.
- IDLE, miss_detected=0: stay.
- memory_data_valid in IDLE: ignored, no write.
- FILL request side:
  - while req_cnt < WORDS_PER_BLOCK: mem_read_en=1, memory_address = base + 2*req_cnt, req_cnt increments each cycle;
  - once req_cnt = WORDS_PER_BLOCK: mem_read_en=0, memory_address holds last issued value.
- FILL receive side:
  - write_data_array = memory_data_valid (combinational); word_index = rcv_cnt;
  - rcv_cnt increments on each valid;
  - words are written in request order.
- FILL completion:
  - on the valid that brings rcv_cnt to WORDS_PER_BLOCK: write_tag_array=1 in that same cycle, alongside the final write_data_array;
  - next state IDLE.
- fsm_busy = (state==FILL); registered, so it is high from the cycle after miss acceptance through the tag-write cycle inclusive.
- Timing, default params, miss accepted at edge T:
  - requests in cycles T+1..T+8 (addresses base..base+14);
  - data writes in T+5..T+12;
  - write_tag_array at T+12;
  - fsm_busy low from T+13.
- Address arithmetic: increments never carry out of the block (base aligned). base 16'hFFF0 requests 16'hFFF0..16'hFFFE with no wrap.
- miss_detected while in FILL (including the tag-write cycle): ignored, latched base unchanged. A re-asserted miss is accepted on the first IDLE cycle.
- Reset mid-fill: abort, no tag write, back to IDLE. Valids still arriving in flight afterwards are ignored (IDLE).
- Back-to-back misses: earliest second acceptance is T+13. Second fill timing is identical to the first.

Test Plan:
- Reset -> all outputs 0, state IDLE; memory_data_valid pulses while idle -> write_data_array stays 0.
- miss_detected=1, miss_address=16'h1236, memory model latency 4 ->
  - memory_address 16'h1230,1232,...,123E in T+1..T+8, mem_read_en high exactly 8 cycles;
  - write_data_array T+5..T+12 with word_index 0..7;
  - write_tag_array only at T+12; fsm_busy high T+1..T+12.
- miss_address=16'hFFFF -> requests 16'hFFF0..16'hFFFE, no wrap to 16'h0000, single tag write.
- miss_detected held high for 20 cycles with address changing from 16'h0040 to 16'h0080 at T+3 ->
  - first fill uses base 16'h0040 only;
  - second fill accepted at T+13 with base 16'h0080.
- Assert rst at T+7 of a fill -> IDLE next cycle, outputs 0, no write_tag_array; remaining valid pulses produce no writes.
- Memory model with irregular valid gaps (words returned at T+5,T+7,T+8,T+11...) -> word_index follows arrival order 0..7; tag write coincides with 8th valid.

Source files
------------

// File: rtl/cache_fill_fsm.sv
// rtl/cache_fill_fsm.sv - cache miss handler that fetches a full block from pipelined memory
//
// Issues WORDS_PER_BLOCK back-to-back word reads for the aligned block containing
// the missing address. Each returned word is written into the data array in arrival
// order. The tag-array write coincides with the last returned word.
//
// Ports:
//   clk                in   clock, rising edge
//   rst                in   synchronous active-high reset
//   miss_detected      in   cache lookup missed this cycle
//   miss_address       in   byte address of the missing access
//   memory_data_valid  in   memory returns one requested word this cycle
//   fsm_busy           out  fill in progress (pipeline stall)
//   mem_read_en        out  read request to memory this cycle
//   memory_address     out  byte address of the current request
//   write_data_array   out  write the returned word into the data array
//   word_index         out  word slot for write_data_array
//   write_tag_array    out  one-cycle pulse: write tag / set valid for the block
module cache_fill_fsm #(
    parameter int WORDS_PER_BLOCK = 8,
    parameter int MEM_LATENCY     = 4
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               miss_detected,
    input  logic [15:0]                        miss_address,
    input  logic                               memory_data_valid,
    output logic                               fsm_busy,
    output logic                               mem_read_en,
    output logic [15:0]                        memory_address,
    output logic                               write_data_array,
    output logic [$clog2(WORDS_PER_BLOCK)-1:0] word_index,
    output logic                               write_tag_array
);

    localparam int IW    = $clog2(WORDS_PER_BLOCK);
    // Counters need one extra bit so they can reach WORDS_PER_BLOCK itself.
    localparam int CW    = IW + 1;
    // Byte offset width within a block (16-bit words, so one more than IW).
    localparam int OFF_W = IW + 1;

    localparam logic [CW-1:0] C_WORDS = CW'(WORDS_PER_BLOCK);
    localparam logic [CW-1:0] C_LAST  = CW'(WORDS_PER_BLOCK - 1);
    localparam logic [IW-1:0] C_IDX_LAST = IW'(WORDS_PER_BLOCK - 1);

    // The FSM counts returned valids rather than timing them, so latency is unused.
    localparam int unused_mem_latency = MEM_LATENCY;

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [15:OFF_W]  r_base_hi;
    logic [CW-1:0]    r_req_cnt;
    logic [CW-1:0]    r_rcv_cnt;
    logic [IW-1:0]    w_req_idx;
    logic [OFF_W-1:0] w_unused_addr_lsbs;

    // Offset bits of the miss address are discarded: the fill always starts at the block base.
    assign w_unused_addr_lsbs = miss_address[OFF_W-1:0];

    // After the last request the counter sits at WORDS_PER_BLOCK; the address then
    // holds the last issued word rather than wrapping back to the block base.
    assign w_req_idx = (r_req_cnt == C_WORDS) ? C_IDX_LAST : r_req_cnt[IW-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_base_hi <= '0;
            r_req_cnt <= '0;
            r_rcv_cnt <= '0;
        end else begin
            r_state <= w_state_next;
            if (r_state == IDLE) begin
                if (miss_detected) begin
                    r_base_hi <= miss_address[15:OFF_W];
                    r_req_cnt <= '0;
                    r_rcv_cnt <= '0;
                end
            end else begin
                if (r_req_cnt != C_WORDS) begin
                    r_req_cnt <= r_req_cnt + CW'(1);
                end
                if (memory_data_valid) begin
                    r_rcv_cnt <= r_rcv_cnt + CW'(1);
                end
            end
        end
    end

    always_comb begin
        w_state_next     = r_state;
        mem_read_en      = 1'b0;
        memory_address   = 16'h0000;
        write_data_array = 1'b0;
        word_index       = '0;
        write_tag_array  = 1'b0;
        case (r_state)
            IDLE: begin
                if (miss_detected) begin
                    w_state_next = FILL;
                end
            end
            FILL: begin
                mem_read_en      = (r_req_cnt != C_WORDS);
                memory_address   = {r_base_hi, w_req_idx, 1'b0};
                write_data_array = memory_data_valid;
                word_index       = r_rcv_cnt[IW-1:0];
                // Tag write rides along with the final data write.
                if (memory_data_valid && (r_rcv_cnt == C_LAST)) begin
                    write_tag_array = 1'b1;
                    w_state_next    = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    assign fsm_busy = (r_state == FILL);

endmodule

// File: tb/tb_cache_fill_fsm.sv
// tb/tb_cache_fill_fsm.sv - directed self-checking bench for cache_fill_fsm
module tb_cache_fill_fsm;

    logic        clk;
    logic        rst;
    logic        miss_detected;
    logic [15:0] miss_address;
    logic        memory_data_valid;
    logic        fsm_busy;
    logic        mem_read_en;
    logic [15:0] memory_address;
    logic        write_data_array;
    logic [2:0]  word_index;
    logic        write_tag_array;

    int n_cmp;
    int n_fail;

    cache_fill_fsm #(
        .WORDS_PER_BLOCK(8),
        .MEM_LATENCY    (4)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .miss_detected    (miss_detected),
        .miss_address     (miss_address),
        .memory_data_valid(memory_data_valid),
        .fsm_busy         (fsm_busy),
        .mem_read_en      (mem_read_en),
        .memory_address   (memory_address),
        .write_data_array (write_data_array),
        .word_index       (word_index),
        .write_tag_array  (write_tag_array)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        rst = 1'b1;
        miss_detected = 1'b0;
        miss_address = 16'h0000;
        memory_data_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({fsm_busy, mem_read_en, write_data_array, write_tag_array} !== 4'b0000) begin
            $display("FAIL reset_ctrl busy/rd/wr/tag got %b want 0000",
                     {fsm_busy, mem_read_en, write_data_array, write_tag_array});
            n_fail++;
        end
        n_cmp++;
        if (memory_address !== 16'h0000) begin
            $display("FAIL reset_addr got %h want 0000", memory_address);
            n_fail++;
        end
        n_cmp++;
        if (word_index !== 3'd0) begin
            $display("FAIL reset_idx got %0d want 0", word_index);
            n_fail++;
        end
        // Stray memory valids while idle must not write anything.
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            memory_data_valid = i[0];
            @(negedge clk);
            n_cmp++;
            if (write_data_array !== 1'b0 || fsm_busy !== 1'b0 || write_tag_array !== 1'b0) begin
                $display("FAIL idle_valid cyc %0d wr=%b busy=%b tag=%b want 0 0 0",
                         i, write_data_array, fsm_busy, write_tag_array);
                n_fail++;
            end
        end
        memory_data_valid = 1'b0;
    endtask

    // Runs one fill starting from an idle cycle; mask bit t means memory returns a word in cycle T+t.
    task automatic do_fill(input string name, input logic [15:0] addr, input logic [15:0] addr2,
                           input int switch_t, input int hold_t, input logic [15:0] base,
                           input logic [31:0] mask);
        int          tag_t;
        int          cnt;
        int          nrcv;
        int          k;
        logic        e_rd;
        logic        e_busy;
        logic        e_wr;
        logic        e_tag;
        logic [15:0] e_addr;
        tag_t = 0;
        cnt   = 0;
        for (int i = 1; i < 32; i++) begin
            if (mask[i] && tag_t == 0) begin
                cnt++;
                if (cnt == 8) tag_t = i;
            end
        end
        nrcv = 0;
        miss_detected = 1'b1;
        miss_address  = addr;
        for (int t = 1; t <= tag_t + 1; t++) begin
            @(posedge clk);
            #1;
            miss_detected = (t <= hold_t);
            if (t == switch_t) miss_address = addr2;
            memory_data_valid = mask[t];
            @(negedge clk);
            e_rd   = (t <= 8);
            e_busy = (t <= tag_t);
            e_wr   = mask[t] && (t <= tag_t);
            e_tag  = (t == tag_t);
            k      = (t < 8) ? t : 8;
            e_addr = base + 16'(2 * (k - 1));
            n_cmp++;
            if (mem_read_en !== e_rd) begin
                $display("FAIL %s rd T+%0d got %b want %b", name, t, mem_read_en, e_rd);
                n_fail++;
            end
            n_cmp++;
            if (fsm_busy !== e_busy) begin
                $display("FAIL %s busy T+%0d got %b want %b", name, t, fsm_busy, e_busy);
                n_fail++;
            end
            n_cmp++;
            if (write_data_array !== e_wr) begin
                $display("FAIL %s wr T+%0d got %b want %b", name, t, write_data_array, e_wr);
                n_fail++;
            end
            n_cmp++;
            if (write_tag_array !== e_tag) begin
                $display("FAIL %s tag T+%0d got %b want %b", name, t, write_tag_array, e_tag);
                n_fail++;
            end
            if (e_busy) begin
                n_cmp++;
                if (memory_address !== e_addr) begin
                    $display("FAIL %s addr T+%0d got %h want %h", name, t, memory_address, e_addr);
                    n_fail++;
                end
            end
            if (e_wr) begin
                n_cmp++;
                if (word_index !== 3'(nrcv)) begin
                    $display("FAIL %s idx T+%0d got %0d want %0d", name, t, word_index, nrcv);
                    n_fail++;
                end
                nrcv++;
            end
        end
        memory_data_valid = 1'b0;
    endtask

    task automatic test_basic_fill();
        do_fill("basic", 16'h1236, 16'h1236, 0, 0, 16'h1230, 32'h0000_1FE0);
    endtask

    task automatic test_top_of_memory();
        do_fill("top", 16'hFFFF, 16'hFFFF, 0, 0, 16'hFFF0, 32'h0000_1FE0);
    endtask

    task automatic test_back_to_back();
        // Miss stays high; address switches at T+3 but the first fill keeps base 0x0040.
        do_fill("b2b_first", 16'h0040, 16'h0080, 3, 99, 16'h0040, 32'h0000_1FE0);
        do_fill("b2b_second", 16'h0080, 16'h0080, 0, 6, 16'h0080, 32'h0000_1FE0);
    endtask

    task automatic test_reset_mid_fill();
        miss_detected = 1'b1;
        miss_address  = 16'h2000;
        for (int t = 1; t <= 14; t++) begin
            @(posedge clk);
            #1;
            miss_detected = 1'b0;
            rst = (t == 7);
            memory_data_valid = (t >= 5 && t <= 12);
            @(negedge clk);
            if (t <= 6) begin
                n_cmp++;
                if (fsm_busy !== 1'b1) begin
                    $display("FAIL rst_mid busy_pre T+%0d got %b want 1", t, fsm_busy);
                    n_fail++;
                end
            end
            if (t >= 8) begin
                n_cmp++;
                if ({fsm_busy, mem_read_en, write_data_array, write_tag_array} !== 4'b0000) begin
                    $display("FAIL rst_mid ctrl T+%0d got %b want 0000", t,
                             {fsm_busy, mem_read_en, write_data_array, write_tag_array});
                    n_fail++;
                end
                n_cmp++;
                if (memory_address !== 16'h0000 || word_index !== 3'd0) begin
                    $display("FAIL rst_mid addr/idx T+%0d got %h/%0d want 0000/0",
                             t, memory_address, word_index);
                    n_fail++;
                end
            end
        end
        rst = 1'b0;
        memory_data_valid = 1'b0;
    endtask

    task automatic test_irregular_valids();
        // Words return at T+5,7,8,11,13,14,16,18.
        do_fill("gaps", 16'h4A5C, 16'h4A5C, 0, 0, 16'h4A50, 32'h0005_69A0);
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        test_reset();
        test_basic_fill();
        test_top_of_memory();
        test_back_to_back();
        test_reset_mid_fill();
        test_irregular_valids();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
